// File: rtl/nmi_sram_resp.sv
// rtl/nmi_sram_resp.sv - NMI responder backed by a word-organised scratch SRAM with wait states
// Optional: define NMI_RESP_OOR_FLAG_EN to add the sticky oor_o / oor_addr_o miss report.
module nmi_sram_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        nmi_valid_i,
  input  logic [31:0] nmi_addr_i,
  input  logic [31:0] nmi_wdata_i,
  input  logic [3:0]  nmi_wstrb_i,
  output logic        nmi_ready_o,
`ifdef NMI_RESP_OOR_FLAG_EN
  output logic [31:0] nmi_rdata_o,
  output logic        oor_o,
  output logic [31:0] oor_addr_o
`else
  output logic [31:0] nmi_rdata_o
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int AW = IW + 2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_capture;

  logic [IW-1:0]   r_idx;
  logic            r_hit;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req_hit;
  logic [IW-1:0]   w_req_idx;
  logic            w_sel_hit;
  logic [IW-1:0]   w_sel_idx;
  logic            w_enter_ack;
  logic            w_we;
  logic            w_unused;

  assign w_req_hit = (nmi_addr_i[31:AW] == BASE_ADDR[31:AW]);
  assign w_req_idx = nmi_addr_i[AW-1:2];
  assign w_unused  = &{1'b0, nmi_addr_i[1:0]};

  // With zero wait states ACK is entered straight from IDLE, so decode must come from the live request.
  assign w_sel_hit   = (r_state == ST_IDLE) ? w_req_hit : r_hit;
  assign w_sel_idx   = (r_state == ST_IDLE) ? w_req_idx : r_idx;
  assign w_enter_ack = (w_state_nxt == ST_ACK) && (r_state != ST_ACK);

  assign nmi_ready_o = (r_state == ST_ACK);
  assign nmi_rdata_o = r_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (nmi_valid_i) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!nmi_valid_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_hit   <= 1'b0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_idx   <= w_req_idx;
        r_hit   <= w_req_hit;
        r_wdata <= nmi_wdata_i;
        r_wstrb <= nmi_wstrb_i;
      end
      if (w_enter_ack) begin
        r_rdata <= w_sel_hit ? r_mem[w_sel_idx] : 32'h0;
      end
    end
  end

  // RAM has no reset; the write is gated by rst_i so a reset landing on ACK commits nothing.
  assign w_we = (r_state == ST_ACK) && r_hit && (r_wstrb != 4'h0) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (r_wstrb[k]) begin
          r_mem[r_idx][8*k +: 8] <= r_wdata[8*k +: 8];
        end
      end
    end
  end

`ifdef NMI_RESP_OOR_FLAG_EN
  logic [31:0] r_addr;
  logic [31:0] w_sel_addr;
  logic        r_oor;
  logic [31:0] r_oor_addr;

  assign w_sel_addr = (r_state == ST_IDLE) ? nmi_addr_i : r_addr;
  assign oor_o      = r_oor;
  assign oor_addr_o = r_oor_addr;

  // Only the first miss after reset is recorded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr     <= 32'h0;
      r_oor      <= 1'b0;
      r_oor_addr <= 32'h0;
    end else begin
      if (w_capture) begin
        r_addr <= nmi_addr_i;
      end
      if (w_enter_ack && !w_sel_hit && !r_oor) begin
        r_oor      <= 1'b1;
        r_oor_addr <= w_sel_addr;
      end
    end
  end
`endif

endmodule

// File: doc/nmi_sram_resp.md
Name: nmi_sram_resp

Overview:
- NMI responder (subordinate end of the native memory interface driven by user cores through ahbl2nmi).
- Word-organised on-chip scratch RAM with byte-strobe writes and a programmable number of wait states.
- Out-of-range accesses are always acknowledged, so the initiator never hangs.
- Sits on the NMI fabric beside flash and peripherals; used as user-core scratch memory and as a bench target for NMI initiators.

Parameters:
- BASE_ADDR, 32'h3000_0000: region base; must be aligned to DEPTH*4.
- DEPTH, 256: number of 32-bit words; power of two, 4..4096.
- WAIT_CYCLES, 1: extra cycles between request sampling and ready; 0..15.

Ports:
- clk_i, input, 1: single clock; all logic on its rising edge.
- rst_i, input, 1: reset, asynchronous and active-high.
- nmi_valid_i, input, 1: request valid; held high until ready.
- nmi_addr_i, input, 32: byte address; bits [1:0] ignored.
- nmi_wdata_i, input, 32: write data.
- nmi_wstrb_i, input, 4: byte write enables; 4'b0000 means read.
- nmi_ready_o, output, 1: one-cycle acknowledge.
- nmi_rdata_o, output, 32: read data, valid while nmi_ready_o=1.

Behaviour:
- Clock/reset interface: one clock; reset is asynchronous and active-high.
- Reset values: nmi_ready_o=0, nmi_rdata_o=32'h0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Address decode:
  - hit = (nmi_addr_i[31:log2(DEPTH*4)] == BASE_ADDR[31:log2(DEPTH*4)]).
  - idx = nmi_addr_i[log2(DEPTH*4)-1:2].
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on nmi_valid_i=1, latch addr, wdata, wstrb and hit. Go to WAIT with counter=WAIT_CYCLES-1, or directly to ACK if WAIT_CYCLES=0.
  - WAIT: decrement counter. At 0 go to ACK. If nmi_valid_i drops (protocol violation), abort to IDLE: no write, no ready.
  - ACK: nmi_ready_o=1 for exactly one cycle, then IDLE unconditionally.
- Latency: nmi_valid_i first high in cycle N gives nmi_ready_o high in cycle N+1+WAIT_CYCLES.
- Back-to-back requests: a new request is sampled in the IDLE cycle after ACK. Minimum period is WAIT_CYCLES+2 cycles.
- Read (wstrb=0):
  - Hit: nmi_rdata_o is loaded with RAM[idx] on the edge entering ACK.
  - Miss: nmi_rdata_o is loaded with 32'h0.
  - nmi_rdata_o holds its value after ACK until the next ACK.
- Write (wstrb≠0):
  - Hit: on the edge leaving ACK, update byte lane k of RAM[idx] for each wstrb[k]=1. Other lanes are unchanged.
  - Miss: write is dropped.
  - nmi_rdata_o is loaded with the pre-write RAM[idx] on a hit (0 on a miss). Software must not rely on this value.
- Request capture: request fields are latched in IDLE. Changes to addr/wdata/wstrb after acceptance are ignored.
- Reset mid-operation: return to IDLE with ready=0, no write committed, RAM retained.
- Simultaneous events: a read followed by a write to the same idx needs no forwarding, because accesses are serialised.

Optional Feature:
- NMI_RESP_OOR_FLAG_EN defined:
  - Adds output oor_o (1): sticky flag set in the ACK cycle of any miss.
  - Adds output oor_addr_o (32): the address of the first miss. Later misses do not overwrite it.
  - Both reset to 0 and are cleared only by rst_i.
- NMI_RESP_OOR_FLAG_EN undefined: both ports and their logic are absent; misses are handled silently as above.

Test Plan:
- WAIT_CYCLES=1: write 32'hA5A5_1234 to 32'h3000_0010 with wstrb=4'hF, then read it → ready exactly 2 cycles after valid; rdata=32'hA5A5_1234.
- Byte strobes: word 32'h1122_3344, write 32'hFFFF_FFFF with wstrb=4'b0101 → read returns 32'h11FF_33FF.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: back-to-back reads → ready at N+1 and N+4 respectively; one-cycle ready pulses; no missed or duplicated acks.
- Miss at 32'h3000_0400 (DEPTH=256):
  - Write is dropped; read returns 32'h0; ready still arrives at the normal latency.
  - With the macro: oor_o=1 and oor_addr_o=32'h3000_0400. A second miss at 32'h4000_0000 leaves oor_addr_o unchanged.
- Reset and abort:
  - Assert rst_i during WAIT of a write to 32'h3000_0020 (old 32'hCAFE_0000) → ready stays 0; after reset a read returns 32'hCAFE_0000.
  - Dropping valid in WAIT also aborts with no write.
- Address alias: write to 32'h3000_0013 → same word as 32'h3000_0010; low address bits are ignored.
